// File: rtl/tm_tx_tracker.sv
// Transaction tracker: counts retired instructions per transaction and issues one stats update per commit.
// Optional saturating abort counter under TM_TRACK_ABORT_CNT_EN; all outputs registered.
module tm_tx_tracker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_begin,
  input  logic             tx_inst,
  input  logic             tx_commit,
  input  logic             tx_abort,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [WIDTH-1:0] AvgTxLen,
  output logic [WIDTH-1:0] InstExed,
  output logic [WIDTH-1:0] CurTxLen,
  input  logic             upd_done,
  input  logic [WIDTH-1:0] AvgTxLen_new,
  input  logic [WIDTH-1:0] InstExed_new,
  output logic             tx_busy,
  output logic             tx_drop
`ifdef TM_TRACK_ABORT_CNT_EN
  ,
  output logic [WIDTH-1:0] abort_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, IN_TX, REQ, WAIT} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  cur_q, cur_d;
  logic [WIDTH-1:0]  avg_q, avg_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              valid_q, busy_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    avg_d   = avg_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_begin) begin
          state_d = IN_TX;
          cur_d   = '0;
        end
      end
      IN_TX: begin
        // Instruction in the commit cycle is counted before the request is built.
        if (tx_inst && (cur_q != {WIDTH{1'b1}})) cur_d = cur_q + 1'b1;
        if (tx_abort)       state_d = IDLE;
        else if (tx_commit) state_d = REQ;
      end
      REQ: begin
        drop_d = tx_begin;
        if (upd_ready) state_d = WAIT;
      end
      WAIT: begin
        drop_d = tx_begin;
        if (upd_done) begin
          avg_d   = AvgTxLen_new;
          cnt_d   = InstExed_new;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      avg_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      avg_q   <= avg_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      valid_q <= (state_d == REQ);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign upd_valid = valid_q;
  assign AvgTxLen  = avg_q;
  assign InstExed  = cnt_q;
  assign CurTxLen  = cur_q;
  assign tx_busy   = busy_q;
  assign tx_drop   = drop_q;

`ifdef TM_TRACK_ABORT_CNT_EN
  logic [WIDTH-1:0] abort_cnt_q;
  logic             abort_hit;

  assign abort_hit = (state_q == IN_TX) && tx_abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      abort_cnt_q <= '0;
    end else if (abort_hit && (abort_cnt_q != {WIDTH{1'b1}})) begin
      abort_cnt_q <= abort_cnt_q + 1'b1;
    end
  end

  assign abort_cnt = abort_cnt_q;
`endif

endmodule
